// File: rtl/axi_lite_slave_regs_if.sv
// AXI-Lite bus bundle between a master and the register-bank responder.
// Five channels: write address, write data, write response, read address, read data.
interface axi_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite register bank: register 0 is a read-only ID, the rest are read/write.
// Contents are exported flat; every committed good write pulses wr_strobe.
module axi_lite_slave_regs #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA11E_0001
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    axi_lite_slave_regs_if.slave           bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic                           wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0]    wr_idx
);
    localparam int                  IDX_W       = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT  = (ADDR_WIDTH + 1)'(NUM_REGS * 4);
    localparam logic [1:0]          RESP_OKAY   = 2'b00;
    localparam logic [1:0]          RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  bvalid;
    logic [1:0]            bresp;

    logic                  rvalid;
    logic [1:0]            rresp;
    logic [DATA_WIDTH-1:0] rdata;

    logic                  aw_ready;
    logic                  w_ready;
    logic                  ar_ready;
    logic                  commit;
    logic                  write_ok;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < ADDR_LIMIT;
    endfunction

    assign aw_ready = !aw_held && !bvalid;
    assign w_ready  = !w_held && !bvalid;
    assign ar_ready = !rvalid;

    assign aw_idx   = aw_addr[2 +: IDX_W];
    assign ar_idx   = bus.ARADDR[2 +: IDX_W];
    assign commit   = aw_held && w_held;
    // Index 0 is the ID register, so a write there is refused like a decode error.
    assign write_ok = addr_in_range(aw_addr) && (aw_idx != '0);

    assign bus.AWREADY = aw_ready;
    assign bus.WREADY  = w_ready;
    assign bus.BVALID  = bvalid;
    assign bus.BRESP   = bresp;
    assign bus.ARREADY = ar_ready;
    assign bus.RVALID  = rvalid;
    assign bus.RRESP   = rresp;
    assign bus.RDATA   = rdata;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr   <= '0;
            w_data    <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            wr_strobe <= 1'b0;
            wr_idx    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;

            if (bus.AWVALID && aw_ready) begin
                aw_held <= 1'b1;
                aw_addr <= bus.AWADDR;
            end
            if (bus.WVALID && w_ready) begin
                w_held <= 1'b1;
                w_data <= bus.WDATA;
            end

            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                if (write_ok) begin
                    regs[aw_idx] <= w_data;
                    bresp        <= RESP_OKAY;
                    wr_strobe    <= 1'b1;
                    wr_idx       <= aw_idx;
                end else begin
                    bresp <= RESP_SLVERR;
                end
            end else if (bvalid && bus.BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Reads sample regs before any same-edge commit lands, returning the old value.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (rvalid) begin
            if (bus.RREADY) begin
                rvalid <= 1'b0;
            end
        end else if (bus.ARVALID) begin
            rvalid <= 1'b1;
            if (!addr_in_range(bus.ARADDR)) begin
                rdata <= '0;
                rresp <= RESP_SLVERR;
            end else if (ar_idx == '0) begin
                rdata <= ID_VALUE;
                rresp <= RESP_OKAY;
            end else begin
                rdata <= regs[ar_idx];
                rresp <= RESP_OKAY;
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = (i == 0) ? ID_VALUE : regs[i];
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Bench for axi_lite_slave_regs: directed scenarios with literal expectations, then
// random AXI-Lite traffic, all shadowed every cycle by a transaction-level model.
module tb_axi_lite_slave_regs;
    localparam int          AW = 32;
    localparam int          DW = 32;
    localparam int          NR = 16;
    localparam logic [31:0] ID = 32'hA11E_0001;

    logic clk;
    logic rst_n;
    logic [NR*DW-1:0]      reg_q;
    logic                  wr_strobe;
    logic [$clog2(NR)-1:0] wr_idx;

    int checks = 0;
    int errors = 0;
    bit done = 0;

    axi_lite_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_slave_regs #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .ID_VALUE(ID)
    ) dut (
        .ACLK(clk), .ARESETn(rst_n), .bus(bus),
        .reg_q(reg_q), .wr_strobe(wr_strobe), .wr_idx(wr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: pending address/data queues, register array,
    // and the response each channel should currently present.
    logic [31:0] mem [NR];
    logic [31:0] aw_q [$];
    logic [31:0] w_q [$];
    bit          m_bvalid;
    logic [1:0]  m_bresp;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    bit          m_strobe;
    int          m_strobe_idx;

    function automatic bit in_range(logic [31:0] a);
        return a < NR * 4;
    endfunction

    function automatic int index_of(logic [31:0] a);
        return int'((a / 4) % NR);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem[i] = '0;
        mem[0] = ID;
        aw_q.delete();
        w_q.delete();
        m_bvalid = 0;
        m_bresp = 2'b00;
        m_rvalid = 0;
        m_rdata = '0;
        m_rresp = 2'b00;
        m_strobe = 0;
        m_strobe_idx = 0;
    endtask

    task automatic model_edge();
        bit take_aw, take_w, both, b_done, r_take, r_done;
        logic [31:0] a, d;
        int k;
        if (!rst_n) begin
            model_reset();
            return;
        end
        take_aw = bus.AWVALID && aw_q.size() == 0 && !m_bvalid;
        take_w  = bus.WVALID && w_q.size() == 0 && !m_bvalid;
        both    = aw_q.size() > 0 && w_q.size() > 0;
        b_done  = m_bvalid && bus.BREADY;
        r_take  = !m_rvalid && bus.ARVALID;
        r_done  = m_rvalid && bus.RREADY;
        m_strobe = 0;
        if (r_take) begin
            m_rvalid = 1;
            if (in_range(bus.ARADDR)) begin
                m_rdata = mem[index_of(bus.ARADDR)];
                m_rresp = 2'b00;
            end else begin
                m_rdata = '0;
                m_rresp = 2'b10;
            end
        end
        if (r_done) m_rvalid = 0;
        if (both) begin
            a = aw_q.pop_front();
            d = w_q.pop_front();
            k = index_of(a);
            m_bvalid = 1;
            if (in_range(a) && k != 0) begin
                mem[k] = d;
                m_bresp = 2'b00;
                m_strobe = 1;
                m_strobe_idx = k;
            end else begin
                m_bresp = 2'b10;
            end
        end
        if (b_done) m_bvalid = 0;
        if (take_aw) aw_q.push_back(bus.AWADDR);
        if (take_w) w_q.push_back(bus.WDATA);
    endtask

    task automatic compare();
        logic [NR*DW-1:0] exp_flat;
        for (int i = 0; i < NR; i++) exp_flat[i*DW +: DW] = mem[i];
        chk("awready", bus.AWREADY, aw_q.size() == 0 && !m_bvalid);
        chk("wready", bus.WREADY, w_q.size() == 0 && !m_bvalid);
        chk("bvalid", bus.BVALID, m_bvalid);
        chk("bresp", bus.BRESP, m_bresp);
        chk("arready", bus.ARREADY, !m_rvalid);
        chk("rvalid", bus.RVALID, m_rvalid);
        chk("rdata", bus.RDATA, m_rdata);
        chk("rresp", bus.RRESP, m_rresp);
        chk("wr_strobe", wr_strobe, m_strobe);
        if (m_strobe) chk("wr_idx", wr_idx, m_strobe_idx);
        checks++;
        if (reg_q !== exp_flat) begin
            errors++;
            $display("FAIL reg_q: got %h, expected %h at %0t", reg_q, exp_flat, $time);
        end
    endtask

    task automatic slot();
        @(posedge clk);
        #4;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        bus.ARVALID = 1'b1;
        bus.ARADDR = a;
        bus.RREADY = 1'b0;
        chk("rd_arready", bus.ARREADY, 1);
        slot();
        bus.ARVALID = 1'b0;
        chk("rd_rvalid", bus.RVALID, 1);
        chk("rd_rdata", bus.RDATA, exp_d);
        chk("rd_rresp", bus.RRESP, exp_r);
        bus.RREADY = 1'b1;
        slot();
        bus.RREADY = 1'b0;
        chk("rd_rvalid_clr", bus.RVALID, 0);
    endtask

    task automatic write_same(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] exp_r, input bit good, input int idx);
        bus.AWVALID = 1'b1;
        bus.AWADDR = a;
        bus.WVALID = 1'b1;
        bus.WDATA = d;
        bus.BREADY = 1'b0;
        slot();
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b0;
        chk("wr_bvalid_early", bus.BVALID, 0);
        chk("wr_awready_held", bus.AWREADY, 0);
        chk("wr_wready_held", bus.WREADY, 0);
        slot();
        chk("wr_bvalid", bus.BVALID, 1);
        chk("wr_bresp", bus.BRESP, exp_r);
        chk("wr_strobe_pulse", wr_strobe, good);
        if (good) chk("wr_idx", wr_idx, idx);
        bus.BREADY = 1'b1;
        slot();
        bus.BREADY = 1'b0;
        chk("wr_bvalid_clr", bus.BVALID, 0);
        chk("wr_strobe_end", wr_strobe, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int s = $urandom_range(0, 9);
        if (s < 8) return 32'($urandom_range(0, NR - 1) * 4 + $urandom_range(0, 3));
        else if (s == 8) return 32'(NR * 4 + $urandom_range(0, 255));
        else return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [NR*DW-1:0] snap;
        logic [NR*DW-1:0] rst_flat;
        bit aw_hs, w_hs, ar_hs;
        rst_n = 1'b0;
        bus.AWVALID = 1'b0; bus.AWADDR = '0;
        bus.WVALID = 1'b0;  bus.WDATA = '0;
        bus.BREADY = 1'b0;
        bus.ARVALID = 1'b0; bus.ARADDR = '0;
        bus.RREADY = 1'b0;
        model_reset();
        rst_flat = '0;
        rst_flat[DW-1:0] = ID;
        fork
            begin
                while (!done) begin
                    @(posedge clk);
                    model_edge();
                    #2;
                    compare();
                end
            end
            begin
                repeat (3) slot();
                chk("rst_bvalid", bus.BVALID, 0);
                chk("rst_rvalid", bus.RVALID, 0);
                chk("rst_strobe", wr_strobe, 0);
                rst_n = 1'b1;

                // ID read and reset contents
                do_read(32'h0, 32'hA11E_0001, 2'b00);
                chk("rst_reg0", reg_q[DW-1:0], 32'hA11E_0001);
                chk("rst_upper_zero", |(reg_q >> DW), 0);

                // AW and W together
                write_same(32'h8, 32'hDEAD_BEEF, 2'b00, 1, 2);
                chk("reg2", reg_q[2*DW +: DW], 32'hDEAD_BEEF);
                do_read(32'h8, 32'hDEAD_BEEF, 2'b00);

                // W three cycles ahead of AW
                bus.WVALID = 1'b1;
                bus.WDATA = 32'h1234;
                slot();
                bus.WVALID = 1'b0;
                chk("wfirst_wready", bus.WREADY, 0);
                chk("wfirst_awready", bus.AWREADY, 1);
                slot();
                slot();
                chk("wfirst_bvalid_wait", bus.BVALID, 0);
                bus.AWVALID = 1'b1;
                bus.AWADDR = 32'h4;
                slot();
                bus.AWVALID = 1'b0;
                chk("wfirst_bvalid_early", bus.BVALID, 0);
                slot();
                chk("wfirst_bvalid", bus.BVALID, 1);
                chk("wfirst_bresp", bus.BRESP, 2'b00);
                chk("wfirst_idx", wr_idx, 1);
                chk("reg1", reg_q[DW +: DW], 32'h1234);
                bus.BREADY = 1'b1;
                slot();
                bus.BREADY = 1'b0;

                // refused writes and out-of-range read
                snap = reg_q;
                write_same(32'h0, 32'hCAFE_0000, 2'b10, 0, 0);
                write_same(32'h40, 32'hCAFE_0040, 2'b10, 0, 0);
                chk("refused_unchanged", reg_q != snap, 0);
                do_read(32'h40, 32'h0, 2'b10);

                // BREADY held low, new AW waits
                bus.AWVALID = 1'b1; bus.AWADDR = 32'hC;
                bus.WVALID = 1'b1;  bus.WDATA = 32'h5555;
                bus.BREADY = 1'b0;
                slot();
                bus.WVALID = 1'b0;
                bus.AWADDR = 32'h10;
                slot();
                chk("hold_bvalid_rise", bus.BVALID, 1);
                for (int k = 0; k < 5; k++) begin
                    slot();
                    chk("hold_bvalid", bus.BVALID, 1);
                    chk("hold_bresp", bus.BRESP, 2'b00);
                    chk("hold_awready", bus.AWREADY, 0);
                    chk("hold_wready", bus.WREADY, 0);
                end
                bus.BREADY = 1'b1;
                slot();
                bus.BREADY = 1'b0;
                chk("hold_bvalid_clr", bus.BVALID, 0);
                chk("hold_awready_back", bus.AWREADY, 1);
                slot();
                bus.AWVALID = 1'b0;
                chk("hold_aw_taken", bus.AWREADY, 0);
                bus.WVALID = 1'b1; bus.WDATA = 32'h6666;
                slot();
                bus.WVALID = 1'b0;
                slot();
                chk("hold_second_bvalid", bus.BVALID, 1);
                bus.BREADY = 1'b1;
                slot();
                bus.BREADY = 1'b0;
                chk("reg4", reg_q[4*DW +: DW], 32'h6666);

                // RREADY held low
                bus.ARVALID = 1'b1; bus.ARADDR = 32'hC;
                slot();
                bus.ARVALID = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    slot();
                    chk("rhold_rvalid", bus.RVALID, 1);
                    chk("rhold_rdata", bus.RDATA, 32'h5555);
                    chk("rhold_arready", bus.ARREADY, 0);
                end
                bus.RREADY = 1'b1;
                slot();
                bus.RREADY = 1'b0;
                chk("rhold_rvalid_clr", bus.RVALID, 0);
                chk("rhold_arready_back", bus.ARREADY, 1);

                // async reset with aw_held and RVALID pending
                bus.AWVALID = 1'b1; bus.AWADDR = 32'h14;
                bus.ARVALID = 1'b1; bus.ARADDR = 32'h8;
                slot();
                bus.AWVALID = 1'b0;
                bus.ARVALID = 1'b0;
                chk("pre_rst_awheld", bus.AWREADY, 0);
                chk("pre_rst_rvalid", bus.RVALID, 1);
                #1;
                rst_n = 1'b0;
                #1;
                chk("arst_bvalid", bus.BVALID, 0);
                chk("arst_rvalid", bus.RVALID, 0);
                chk("arst_rdata", bus.RDATA, 0);
                chk("arst_rresp", bus.RRESP, 0);
                chk("arst_bresp", bus.BRESP, 0);
                chk("arst_strobe", wr_strobe, 0);
                chk("arst_wr_idx", wr_idx, 0);
                chk("arst_awready", bus.AWREADY, 1);
                chk("arst_wready", bus.WREADY, 1);
                chk("arst_arready", bus.ARREADY, 1);
                chk("arst_reg_q", reg_q != rst_flat, 0);
                slot();
                slot();
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    slot();
                    chk("post_rst_bvalid", bus.BVALID, 0);
                    chk("post_rst_rvalid", bus.RVALID, 0);
                end
                bus.WVALID = 1'b1; bus.WDATA = 32'h7777;
                slot();
                bus.WVALID = 1'b0;
                slot();
                slot();
                chk("post_rst_no_commit", bus.BVALID, 0);

                // random traffic
                aw_hs = 0; w_hs = 0; ar_hs = 0;
                repeat (3000) begin
                    if (!bus.AWVALID || aw_hs) begin
                        bus.AWVALID = $urandom_range(0, 2) != 0;
                        bus.AWADDR = rand_addr();
                    end
                    if (!bus.WVALID || w_hs) begin
                        bus.WVALID = $urandom_range(0, 2) != 0;
                        bus.WDATA = $urandom();
                    end
                    if (!bus.ARVALID || ar_hs) begin
                        bus.ARVALID = $urandom_range(0, 2) != 0;
                        bus.ARADDR = rand_addr();
                    end
                    bus.BREADY = $urandom_range(0, 3) != 0;
                    bus.RREADY = $urandom_range(0, 3) != 0;
                    aw_hs = bus.AWVALID && bus.AWREADY;
                    w_hs = bus.WVALID && bus.WREADY;
                    ar_hs = bus.ARVALID && bus.ARREADY;
                    slot();
                end
                bus.AWVALID = 1'b0;
                bus.WVALID = 1'b0;
                bus.ARVALID = 1'b0;
                bus.BREADY = 1'b1;
                bus.RREADY = 1'b1;
                repeat (5) slot();
                done = 1;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
